wb_sdram_traffic_gen: RTL and testbench
=======================================

Name: wb_sdram_traffic_gen

Overview:
- Synthesizable, parametrised Wishbone master traffic generator and self-checker. It replaces hand-driven wb_* stimulus in front of sdrc_top.
- Waits for sdr_init_done, then writes cfg_num_bursts bursts of a programmable pattern starting at cfg_base_addr.
- Reads the same region back, regenerates the expected pattern and compares.
- Reports pass/fail, error count and first failing address, so the same block serves simulation and FPGA bring-up.

Parameters:
- DW, 32, Wishbone data width (8/16/32/64); byte step per beat = DW/8.
- AW, 26, Wishbone byte-address width.
- MAX_BURST, 8, maximum beats per burst.
- CNT_W, 16, width of burst count and error counter.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- sdr_init_done  in  1  SDRAM initialisation complete.
- cfg_base_addr  in  AW  start byte address; sampled on accepted start.
- cfg_num_bursts  in  CNT_W  bursts per phase; sampled on start.
- cfg_burst_len  in  4  beats per burst; sampled on start.
- cfg_mode  in  2  pattern: 00 incrementing, 01 LFSR, 10 walking-one, 11 address-as-data.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_addr_o  out  AW  byte address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte selects; always all ones.
- wb_cti_o  out  3  cycle type.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  read data.
- busy, done, pass  out  1 each  status outputs.
- err_cnt  out  CNT_W  read-data mismatch count.
- first_err_addr  out  AW  address of the first mismatch.

Behaviour:
- Reset values: all wb_*_o = 0 except wb_sel_o = all ones. busy = 0, done = 0, pass = 0, err_cnt = 0, first_err_addr = 0. State = IDLE.
- If reset asserts mid-transfer, cyc and stb drop at the next edge and the cycle is abandoned.
- FSM states: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE.
  - IDLE/DONE + start → WAIT_INIT. Config is latched, counters and the pattern generator are cleared, done and pass go low, busy goes high.
  - WAIT_INIT → WR_BURST when sdr_init_done = 1. If cfg_num_bursts = 0, go straight to DONE with pass = 1.
  - WR_BURST: cyc = stb = we = 1. Address and data are held stable until ack. Each ack advances beat, address (+DW/8, modulo 2^AW) and pattern.
  - After the last beat's ack → WR_GAP: exactly one cycle with cyc = stb = 0. Then the next burst, or RD_BURST with address and pattern reset to their base values.
  - RD_BURST/RD_GAP mirror the write phase with we = 0. wb_dat_i is compared to the expected pattern in the ack cycle.
  - After the last read burst → DONE. Set done = 1, busy = 0, pass = (err_cnt == 0). done is held until the next accepted start.
- Cycle type: wb_cti_o = 010 on non-final beats and 111 on the final beat. A 1-beat burst uses 111. cti = 000 when idle.
- Burst length rules: cfg_burst_len = 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- Errors:
  - err_cnt saturates at all ones.
  - first_err_addr is captured only when err_cnt goes 0 → 1.
  - A mismatch and an ack on the last beat in the same cycle are both counted.
- A start pulse while busy is ignored.
- No transfer timeout: stb is held until ack arrives.
- Patterns (beat index i counts from 0 within each phase):
  - 00: i zero-extended to DW.
  - 01: 32-bit Galois LFSR, polynomial 0x80200003, seed 0xACE10001, advanced per ack, replicated or truncated to DW.
  - 10: 1 << (i mod DW).
  - 11: the current byte address zero-extended.

Decomposition:
- Package tg_pkg holds: mode encodings, state enum, CTI constants (CTI_CLASSIC = 000, CTI_INCR = 010, CTI_EOB = 111), LFSR seed and polynomial.
- Sub-module tg_pattern_gen (parameter DW): inputs clear, advance, mode, addr; output the pattern word.
- One instance is shared by the write and read phases and cleared at each phase start.

Test Plan:
- Reset, wait 2000 cycles, sdr_init_done = 1; start with base = 0x0, bursts = 4, len = 4, mode = 00 → 16 writes then 16 reads. Data 0..15 at addresses 0x00..0x3C, done = 1, pass = 1, err_cnt = 0.
- Mode 01, len = 8, bursts = 2; slave model corrupts read beat 5 (XOR 0x1) → err_cnt = 1, first_err_addr = 0x14, pass = 0.
- len = 0 and len = 12 with MAX_BURST = 8 → single-beat bursts with cti = 111, and 8-beat bursts with cti = 010×7 then 111.
- Slave inserts 0–3 random wait states per beat; check stb/addr/dat stay stable until ack and that one gap cycle separates bursts.
- base = 0x3FFFFF8, 4 beats, DW = 32 → addresses 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004; mode 11 data matches the wrapped addresses.
- Assert wb_rst_i during RD_BURST beat 2 → next cycle cyc = stb = 0, all status reset. bursts = 0 → done one cycle after WAIT_INIT with pass = 1 and no Wishbone activity.

Source files
------------

// File: rtl/tg_pkg.sv
// Shared types and constants for the Wishbone SDRAM traffic generator:
// pattern modes, FSM states, cycle-type codes and LFSR parameters.
package tg_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_LFSR = 2'b01,
    MODE_WALK = 2'b10,
    MODE_ADDR = 2'b11
  } tg_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR_BURST,
    ST_WR_GAP,
    ST_RD_BURST,
    ST_RD_GAP,
    ST_DONE
  } tg_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return (state >> 1) ^ (state[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/tg_pattern_gen.sv
// Data pattern source shared by the write and read phases. The word on
// o_pattern belongs to the current beat; i_advance steps to the next beat.
module tg_pattern_gen
  import tg_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 26
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_advance,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_pattern
);

  localparam int LOG_DW = $clog2(DW);
  localparam int REP    = (DW + 31) / 32;

  logic [DW-1:0] r_idx;
  logic [31:0]   r_lfsr;
  logic [DW-1:0] w_walk;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_idx  <= r_idx + DW'(1);
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_walk = {{(DW-1){1'b0}}, 1'b1} << r_idx[LOG_DW-1:0];

  always_comb begin
    // NOTE: default assignment first so every path drives o_pattern; no latch.
    o_pattern = r_idx;
    case (i_mode)
      MODE_LFSR: o_pattern = DW'({REP{r_lfsr}});
      MODE_WALK: o_pattern = w_walk;
      MODE_ADDR: o_pattern = DW'(i_addr);
      default:   o_pattern = r_idx;
    endcase
  end

endmodule

// File: rtl/wb_sdram_traffic_gen.sv
// Wishbone burst master that writes a pattern region, reads it back and
// checks it, reporting pass/fail, error count and first failing address.
module wb_sdram_traffic_gen
  import tg_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             sdr_init_done,
  input  logic [AW-1:0]    cfg_base_addr,
  input  logic [CNT_W-1:0] cfg_num_bursts,
  input  logic [3:0]       cfg_burst_len,
  input  logic [1:0]       cfg_mode,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [AW-1:0]    wb_addr_o,
  output logic [DW-1:0]    wb_dat_o,
  output logic [DW/8-1:0]  wb_sel_o,
  output logic [2:0]       wb_cti_o,
  input  logic             wb_ack_i,
  input  logic [DW-1:0]    wb_dat_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  localparam logic [AW-1:0] ADDR_STEP = AW'(DW / 8);

  tg_state_e        r_state;
  tg_mode_e         r_mode;
  logic [AW-1:0]    r_base;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_first_err_addr;
  logic [CNT_W-1:0] r_num_bursts;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [3:0]       r_len;
  logic [3:0]       r_beat;
  logic             r_cyc;
  logic             r_we;
  logic [2:0]       r_cti;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [3:0]    w_len_eff;
  logic [2:0]    w_first_cti;
  logic [DW-1:0] w_pattern;
  logic          w_start_ok;
  logic          w_ack;
  logic          w_last_beat;
  logic          w_last_burst;
  logic          w_pat_clear;
  logic          w_mismatch;

  // Zero-length bursts behave as single beats; long ones clamp to MAX_BURST.
  always_comb begin
    w_len_eff = cfg_burst_len;
    if (cfg_burst_len == 4'd0) begin
      w_len_eff = 4'd1;
    end else if (int'(cfg_burst_len) > MAX_BURST) begin
      w_len_eff = 4'(MAX_BURST);
    end
  end

  assign w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_ack        = r_cyc && wb_ack_i;
  assign w_last_beat  = (r_beat == r_len - 4'd1);
  assign w_last_burst = (r_burst_cnt == r_num_bursts);
  assign w_first_cti  = (r_len == 4'd1) ? CTI_EOB : CTI_INCR;
  assign w_pat_clear  = w_start_ok || (r_state == ST_WR_GAP && w_last_burst);
  assign w_mismatch   = w_ack && !r_we && (wb_dat_i != w_pattern);

  tg_pattern_gen #(
    .DW (DW),
    .AW (AW)
  ) u_pattern (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clear   (w_pat_clear),
    .i_advance (w_ack),
    .i_mode    (r_mode),
    .i_addr    (r_addr),
    .o_pattern (w_pattern)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state          <= ST_IDLE;
      r_mode           <= MODE_INC;
      r_base           <= '0;
      r_addr           <= '0;
      r_num_bursts     <= '0;
      r_burst_cnt      <= '0;
      r_len            <= 4'd1;
      r_beat           <= '0;
      r_cyc            <= 1'b0;
      r_we             <= 1'b0;
      r_cti            <= CTI_CLASSIC;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state          <= ST_WAIT_INIT;
            r_mode           <= tg_mode_e'(cfg_mode);
            r_base           <= cfg_base_addr;
            r_addr           <= cfg_base_addr;
            r_num_bursts     <= cfg_num_bursts;
            r_len            <= w_len_eff;
            r_burst_cnt      <= '0;
            r_beat           <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
          end
        end

        ST_WAIT_INIT: begin
          if (sdr_init_done) begin
            if (r_num_bursts == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WR_BURST;
              r_cyc   <= 1'b1;
              r_we    <= 1'b1;
              r_cti   <= w_first_cti;
            end
          end
        end

        // Address, data and cti only move on an ack, so stb is held stable.
        ST_WR_BURST, ST_RD_BURST: begin
          if (w_ack) begin
            r_addr <= r_addr + ADDR_STEP;
            if (w_last_beat) begin
              r_state     <= (r_state == ST_WR_BURST) ? ST_WR_GAP : ST_RD_GAP;
              r_cyc       <= 1'b0;
              r_we        <= 1'b0;
              r_cti       <= CTI_CLASSIC;
              r_beat      <= '0;
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else begin
              r_beat <= r_beat + 4'd1;
              r_cti  <= (r_beat + 4'd2 == r_len) ? CTI_EOB : CTI_INCR;
            end
          end
        end

        ST_WR_GAP: begin
          r_cyc <= 1'b1;
          r_cti <= w_first_cti;
          if (w_last_burst) begin
            r_state     <= ST_RD_BURST;
            r_we        <= 1'b0;
            r_addr      <= r_base;
            r_burst_cnt <= '0;
          end else begin
            r_state <= ST_WR_BURST;
            r_we    <= 1'b1;
          end
        end

        ST_RD_GAP: begin
          if (w_last_burst) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_err_cnt == '0);
          end else begin
            r_state <= ST_RD_BURST;
            r_cyc   <= 1'b1;
            r_cti   <= w_first_cti;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Only the first mismatch of a run records its address.
      if (w_mismatch) begin
        if (r_err_cnt == '0) begin
          r_first_err_addr <= r_addr;
        end
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign wb_cyc_o       = r_cyc;
  assign wb_stb_o       = r_cyc;
  assign wb_we_o        = r_we;
  assign wb_addr_o      = r_addr;
  assign wb_dat_o       = (r_cyc && r_we) ? w_pattern : '0;
  assign wb_sel_o       = '1;
  assign wb_cti_o       = r_cti;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
// Directed bench for wb_sdram_traffic_gen: a Wishbone slave with memory and
// optional wait states, plus a scoreboard that checks every acked beat.
module tb_wb_sdram_traffic_gen;

  localparam int DW        = 32;
  localparam int AW        = 26;
  localparam int MAX_BURST = 8;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             init_done;
  logic [AW-1:0]    cfg_base;
  logic [CNT_W-1:0] cfg_bursts;
  logic [3:0]       cfg_len;
  logic [1:0]       cfg_mode;
  logic             cyc, stb, we;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    dat_o;
  logic [DW/8-1:0]  sel;
  logic [2:0]       cti;
  logic             ack;
  logic [DW-1:0]    dat_i;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_cnt;
  logic [AW-1:0]    first_err;

  always #5 clk = ~clk;

  wb_sdram_traffic_gen #(
    .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start          (start),
    .sdr_init_done  (init_done),
    .cfg_base_addr  (cfg_base),
    .cfg_num_bursts (cfg_bursts),
    .cfg_burst_len  (cfg_len),
    .cfg_mode       (cfg_mode),
    .wb_cyc_o       (cyc),
    .wb_stb_o       (stb),
    .wb_we_o        (we),
    .wb_addr_o      (addr),
    .wb_dat_o       (dat_o),
    .wb_sel_o       (sel),
    .wb_cti_o       (cti),
    .wb_ack_i       (ack),
    .wb_dat_i       (dat_i),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    cti;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  int            n_cmp = 0;
  int            n_err = 0;
  int            max_wait = 0;
  int            corrupt_idx = -1;
  int            rd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of one phase; len is the effective (clamped) burst length.
  task automatic push_phase(input logic wr, input logic [AW-1:0] base, input int bursts,
                            input int len, input logic [1:0] mode);
    logic [AW-1:0] a;
    logic [31:0]   lf;
    int            i;
    beat_t         b;
    a  = base;
    lf = 32'hACE1_0001;
    i  = 0;
    for (int n = 0; n < bursts; n++) begin
      for (int k = 0; k < len; k++) begin
        b.we   = wr;
        b.addr = a;
        b.cti  = (k == len - 1) ? 3'b111 : 3'b010;
        case (mode)
          2'b00:   b.data = DW'(i);
          2'b01:   b.data = lf;
          2'b10:   b.data = DW'(1) << (i % DW);
          default: b.data = DW'(a);
        endcase
        exp_q.push_back(b);
        a  = a + AW'(DW / 8);
        lf = (lf >> 1) ^ (lf[0] ? 32'h8020_0003 : 32'h0);
        i++;
      end
    end
  endtask

  // Slave: decides ack on the falling edge for the next rising edge.
  initial begin : slave
    int wl;
    wl    = 0;
    ack   = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (!rst && cyc && stb) begin
        if (wl == 0) begin
          ack = 1'b1;
          if (we) begin
            mem[addr] = dat_o;
          end else begin
            dat_i = mem.exists(addr) ? mem[addr] : '0;
            if (rd_cnt == corrupt_idx) dat_i = dat_i ^ DW'(1);
            rd_cnt++;
          end
          wl = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end else begin
          wl--;
        end
      end
    end
  end

  // Monitor: pops expected beats on acks, checks hold-until-ack and gaps.
  initial begin : monitor
    beat_t         e;
    logic          pend;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_dat;
    logic          p_we;
    logic          ended;
    int            gap;
    pend  = 1'b0;
    ended = 1'b0;
    gap   = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !busy) begin
        pend  = 1'b0;
        ended = 1'b0;
        gap   = 0;
      end else begin
        if (pend) begin
          check("stb_held", 64'(stb), 64'd1);
          check("addr_held", 64'(addr), 64'(p_addr));
          check("dat_held", 64'(dat_o), 64'(p_dat));
          check("we_held", 64'(we), 64'(p_we));
        end
        if (cyc && stb) begin
          if (ended) begin
            check("gap_len", 64'(gap), 64'd1);
            ended = 1'b0;
          end
          if (ack) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", addr);
            end else begin
              e = exp_q.pop_front();
              check("beat_we", 64'(we), 64'(e.we));
              check("beat_addr", 64'(addr), 64'(e.addr));
              check("beat_cti", 64'(cti), 64'(e.cti));
              if (e.we) check("beat_wdata", 64'(dat_o), 64'(e.data));
            end
            if (cti == 3'b111) begin
              ended = 1'b1;
              gap   = 0;
            end
            pend = 1'b0;
          end else begin
            pend   = 1'b1;
            p_addr = addr;
            p_dat  = dat_o;
            p_we   = we;
          end
        end else begin
          pend = 1'b0;
          if (ended) gap++;
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input int bursts, input int len,
                          input logic [1:0] mode);
    @(negedge clk);
    rd_cnt     = 0;
    cfg_base   = base;
    cfg_bursts = CNT_W'(bursts);
    cfg_len    = 4'(len);
    cfg_mode   = mode;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic end_checks(input string name, input int e_err, input logic [AW-1:0] e_first,
                            input logic e_pass);
    check({name, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    check({name, "_first_err"}, 64'(first_err), 64'(e_first));
    check({name, "_pass"}, 64'(pass), 64'(e_pass));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  seen;
    logic found;
    rst        = 1'b1;
    start      = 1'b0;
    init_done  = 1'b0;
    cfg_base   = '0;
    cfg_bursts = '0;
    cfg_len    = '0;
    cfg_mode   = '0;
    repeat (3) @(negedge clk);

    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_stb", 64'(stb), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_sel", 64'(sel), 64'hF);
    check("rst_cti", 64'(cti), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_first_err", 64'(first_err), 64'd0);
    rst = 1'b0;

    // Incrementing pattern, 4x4 beats, start issued before SDRAM init.
    push_phase(1'b1, '0, 4, 4, 2'b00);
    push_phase(1'b0, '0, 4, 4, 2'b00);
    do_start('0, 4, 4, 2'b00);
    seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (cyc) seen++;
    end
    check("t1_no_cyc_before_init", 64'(seen), 64'd0);
    check("t1_busy_in_wait_init", 64'(busy), 64'd1);
    init_done = 1'b1;
    wait_done("t1");
    end_checks("t1", 0, '0, 1'b1);
    check("t1_mem_0x3c", 64'(mem[26'h3C]), 64'd15);

    // LFSR, 2x8 beats, read beat 5 corrupted, ignored start mid-run.
    max_wait    = 3;
    corrupt_idx = 5;
    push_phase(1'b1, '0, 2, 8, 2'b01);
    push_phase(1'b0, '0, 2, 8, 2'b01);
    do_start('0, 2, 8, 2'b01);
    repeat (20) @(negedge clk);
    cfg_base   = 26'h400;
    cfg_bursts = 16'd9;
    cfg_mode   = 2'b11;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_busy_after_ignored_start", 64'(busy), 64'd1);
    wait_done("t2");
    end_checks("t2", 1, 26'h14, 1'b0);
    corrupt_idx = -1;

    // len = 0 acts as single beats; len = 12 clamps to 8.
    push_phase(1'b1, 26'h100, 3, 1, 2'b10);
    push_phase(1'b0, 26'h100, 3, 1, 2'b10);
    do_start(26'h100, 3, 0, 2'b10);
    wait_done("t3a");
    end_checks("t3a", 0, '0, 1'b1);
    push_phase(1'b1, 26'h200, 2, 8, 2'b10);
    push_phase(1'b0, 26'h200, 2, 8, 2'b10);
    do_start(26'h200, 2, 12, 2'b10);
    wait_done("t3b");
    end_checks("t3b", 0, '0, 1'b1);
    check("t3b_mem_walk15", 64'(mem[26'h23C]), 64'h8000);

    // Address wrap at the top of the 26-bit space, address-as-data.
    push_phase(1'b1, 26'h3FF_FFF8, 1, 4, 2'b11);
    push_phase(1'b0, 26'h3FF_FFF8, 1, 4, 2'b11);
    do_start(26'h3FF_FFF8, 1, 4, 2'b11);
    wait_done("t4");
    end_checks("t4", 0, '0, 1'b1);
    check("t4_mem_wrap0", 64'(mem[26'h0]), 64'h0);
    check("t4_mem_wrap4", 64'(mem[26'h4]), 64'h4);
    check("t4_mem_top", 64'(mem[26'h3FF_FFFC]), 64'h3FF_FFFC);

    // Reset while read beat 2 is on the bus.
    max_wait = 1;
    push_phase(1'b1, '0, 2, 4, 2'b00);
    push_phase(1'b0, '0, 2, 4, 2'b00);
    do_start('0, 2, 4, 2'b00);
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      #2;
      if (cyc && !we && addr == 26'h8) found = 1'b1;
    end
    check("t5_reached_rd_beat2", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_cyc", 64'(cyc), 64'd0);
    check("t5_stb", 64'(stb), 64'd0);
    check("t5_cti", 64'(cti), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
    exp_q.delete();
    rst = 1'b0;

    // Zero bursts: done one cycle after WAIT_INIT, no bus activity.
    do_start(26'h80, 0, 4, 2'b00);
    check("t6_busy_wait_init", 64'(busy), 64'd1);
    check("t6_done_low", 64'(done), 64'd0);
    check("t6_cyc_wait_init", 64'(cyc), 64'd0);
    @(negedge clk);
    check("t6_done", 64'(done), 64'd1);
    check("t6_pass", 64'(pass), 64'd1);
    check("t6_busy_done", 64'(busy), 64'd0);
    check("t6_cyc_done", 64'(cyc), 64'd0);
    repeat (3) @(negedge clk);
    check("t6_done_held", 64'(done), 64'd1);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
